// File: rtl/dac_pkg.sv
// Shared AXI4-Lite response codes, default register base and decode kinds
// for the control-register slice.
package dac_pkg;

   localparam logic [1:0]  RESP_OKAY         = 2'b00;
   localparam logic [1:0]  RESP_SLVERR       = 2'b10;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

   typedef enum logic [1:0] {
      KIND_RW       = 2'd0,
      KIND_RO       = 2'd1,
      KIND_UNMAPPED = 2'd2
   } reg_kind_e;

endpackage

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS read/write control registers plus one
// read-only status word; write and read channels run independently.
module axil_reg_bank
   import dac_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                NUM_REGS  = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [ADDR_W-1:0]            araddr,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [DATA_W-1:0]            rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   output logic [NUM_REGS-1:0]          wr_stb_o,
   input  logic [DATA_W-1:0]            status_i
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = $clog2(NUM_REGS + 1);

   typedef struct packed {
      reg_kind_e        kind;
      logic [IDX_W-1:0] idx;
   } dec_t;

   // Word index relative to BASE_ADDR; the byte offset bits drop out in the shift.
   function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] word;
      dec_t              d;
      word   = (addr - BASE_ADDR) >> 2;
      d.kind = KIND_UNMAPPED;
      d.idx  = '0;
      if (addr >= BASE_ADDR) begin
         if (word < ADDR_W'(NUM_REGS)) begin
            d.kind = KIND_RW;
            d.idx  = IDX_W'(word);
         end else if (word == ADDR_W'(NUM_REGS)) begin
            d.kind = KIND_RO;
            d.idx  = IDX_W'(NUM_REGS);
         end
      end
      return d;
   endfunction

   logic                aw_held_q, aw_held_d;
   logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
   logic                w_held_q, w_held_d;
   logic [DATA_W-1:0]   w_data_q, w_data_d;
   logic [STRB_W-1:0]   w_strb_q, w_strb_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic                rvalid_q, rvalid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;

   dec_t                wr_dec;
   dec_t                rd_dec;
   logic                commit;
   logic [DATA_W-1:0]   rd_word;

   assign awready = ~aw_held_q & ~bvalid_q;
   assign wready  = ~w_held_q & ~bvalid_q;
   assign arready = ~rvalid_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign wr_stb_o = wr_stb_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign wr_dec = decode(aw_addr_q);
   assign rd_dec = decode(araddr);
   // Commit only once per held pair: bvalid blocks re-commit until the response drains.
   assign commit = aw_held_q & w_held_q & ~bvalid_q;

   always_comb begin
      aw_held_d = aw_held_q;
      aw_addr_d = aw_addr_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      wr_stb_d  = '0;
      regs_d    = regs_q;
      if (awvalid && awready) begin
         aw_held_d = 1'b1;
         aw_addr_d = awaddr;
      end
      if (wvalid && wready) begin
         w_held_d = 1'b1;
         w_data_d = wdata;
         w_strb_d = wstrb;
      end
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = (wr_dec.kind == KIND_RW) ? RESP_OKAY : RESP_SLVERR;
         if (wr_dec.kind == KIND_RW) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (wr_dec.idx == IDX_W'(i)) begin
                  wr_stb_d[i] = 1'b1;
                  for (int b = 0; b < STRB_W; b++) begin
                     if (w_strb_q[b]) regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
                  end
               end
            end
         end
      end
      if (bvalid_q && bready) begin
         bvalid_d  = 1'b0;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end
   end

   // Reads sample regs_q, so a read accepted in a commit cycle sees the old value.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rd_word  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_dec.idx == IDX_W'(i)) rd_word = regs_q[i];
      end
      if (arvalid && arready) begin
         rvalid_d = 1'b1;
         unique case (rd_dec.kind)
            KIND_RW: begin
               rdata_d = rd_word;
               rresp_d = RESP_OKAY;
            end
            KIND_RO: begin
               rdata_d = status_i;
               rresp_d = RESP_OKAY;
            end
            default: begin
               rdata_d = '0;
               rresp_d = RESP_SLVERR;
            end
         endcase
      end else if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held_q <= 1'b0;
         aw_addr_q <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         wr_stb_q  <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         aw_addr_q <= aw_addr_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         wr_stb_q  <= wr_stb_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         regs_q    <= regs_d;
      end
   end

endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, AXI address width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of read/write control registers (1..64).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h4000_0000, byte address of register 0.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have AXI4-Lite write ports: awaddr in ADDR_W; awvalid in 1; awready out 1; wdata in DATA_W; wstrb in DATA_W/8; wvalid in 1; wready out 1; bresp out 2; bvalid out 1; bready in 1.
REQ-007 SHALL have AXI4-Lite read ports: araddr in ADDR_W; arvalid in 1; arready out 1; rdata out DATA_W; rresp out 2; rvalid out 1; rready in 1.
REQ-008 SHALL have regs_o  out  NUM_REGS*DATA_W  flattened register contents, register i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have wr_stb_o  out  NUM_REGS  one-cycle pulse per register on each committed write.
REQ-010 SHALL have status_i  in  DATA_W  read-only status word at index NUM_REGS.

Function
REQ-011 SHALL decode index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored; addr < BASE_ADDR is unmapped.
REQ-012 SHALL treat indices 0..NUM_REGS-1 as RW, index NUM_REGS as RO (status_i), all others as unmapped.
REQ-013 SHALL drive awready high only when no AW is held and bvalid is low; AW is captured on awvalid&&awready.
REQ-014 SHALL drive wready high only when no W is held and bvalid is low; W (data+strobe) is captured on wvalid&&wready.
REQ-015 SHALL accept AW and W in any order or the same cycle; the write commits in the first cycle both are held.
REQ-016 SHALL, on commit to an RW index, update only bytes whose wstrb bit is 1, and pulse that index's wr_stb_o for exactly that cycle (also when wstrb==0).
REQ-017 SHALL assert bvalid the cycle after commit with bresp 2'b00 (RW index) or 2'b10 SLVERR (RO or unmapped; no register change, no strobe).
REQ-018 SHALL hold bvalid and bresp stable until bvalid&&bready, then clear held AW/W; back-to-back throughput at most one write per 3 cycles.
REQ-019 SHALL drive arready = ~rvalid; on arvalid&&arready, rdata/rresp SHALL be registered and rvalid asserted the next cycle.
REQ-020 SHALL return register value (RW), status_i sampled at accept cycle (RO) with rresp 2'b00, or 0 with rresp 2'b10 (unmapped).
REQ-021 SHALL hold rvalid, rdata, rresp stable until rvalid&&rready.
REQ-022 SHALL, when a read is accepted in the same cycle a write commits to the same index, return the pre-write value.
REQ-023 SHALL run read and write channels independently; neither stalls the other.
REQ-024 SHALL update regs_o in the cycle after commit (registered outputs, no combinational path from AXI inputs).

Reset
REQ-025 SHALL, on rst, clear all registers, regs_o, wr_stb_o, bvalid, rvalid, rdata, bresp, rresp, and held AW/W flags to 0.
REQ-026 SHALL, on rst mid-transaction, discard held AW/W and pending responses with no commit; awready, wready, arready SHALL be 1 the cycle after rst deasserts.

Structure
REQ-027 SHALL place AXI response codes (OKAY=2'b00, SLVERR=2'b10) and default BASE_ADDR in shared package dac_pkg.
REQ-028 SHALL be one module with no sub-module; the address decoder is a local function used by both channels.

Verification
REQ-029 Write 32'hDEADBEEF, wstrb 4'hF to 0x4000_0004, AW and W same cycle -> bvalid next cycle, bresp 00, wr_stb_o=8'b0000_0010 one cycle, regs_o[1]=DEADBEEF.
REQ-030 W 32'h0000_00AA strb 4'b0001 two cycles before AW to 0x4000_0004 -> regs_o[1]=DEADBEAA, bresp 00.
REQ-031 Write to 0x4000_0020 (status) and 0x4000_0100 -> bresp 10, no strobe, regs unchanged; reading 0x4000_0020 with status_i=32'h1234 -> rdata 1234, rresp 00; reading 0x4000_0100 -> rdata 0, rresp 10.
REQ-032 bready held low 10 cycles -> bvalid/bresp stable, awready and wready low throughout; rready low -> rdata stable, arready low.
REQ-033 Read 0x4000_0000 accepted in commit cycle of write 0x5 to same address -> rdata old value 0; next read -> 0x5.
REQ-034 rst asserted with AW held and W not yet sent -> after rst no bvalid, all regs 0, awready=wready=arready=1.
